terminal_fifo: RTL
==================

Name: terminal_fifo

Overview:
Memory-mapped debug terminal for the pipelined CPU. It is the parametrised successor of the single-byte terminal port. CPU stores to a DATA register push bytes into a FIFO of depth FIFO_DEPTH, which drains over a valid/ready byte stream to a downstream consumer (UART or display). A LINE_BYTES-wide shift buffer of recent characters is kept for on-chip display and debug, along with STATUS/CTRL registers, sticky overflow and a drain interrupt.

Parameters:
BASE_ADDR, 32'h0000_0000, block selected when addr[31:8] == BASE_ADDR[31:8]
FIFO_DEPTH, 16, FIFO entries; power of two, 2..256
LINE_BYTES, 16, bytes held in line_buf

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
we  input  1  CPU write strobe
re  input  1  CPU read strobe
addr  input  32  byte address; offsets addr[7:0]: 0x00 DATA, 0x04 STATUS, 0x08 CTRL
data_write  input  32  CPU write data
data_read  output  32  CPU read data, combinational
tx_data  output  8  FIFO head byte
tx_valid  output  1  head byte available
tx_ready  input  1  consumer accepts byte
line_buf  output  8*LINE_BYTES  recent characters, newest in [7:0]
irq  output  1  FIFO-drained interrupt

Behaviour:
- Reset: clk and reset_n (asynchronous, active-low) as decided. On reset: FIFO empty (pointers and count = 0), overflow = 0, line_buf = 0, CTRL = 32'h1 (tx_en = 1, lf_clear = 0, irq_en = 0), tx_data = 0, tx_valid = 0, irq = 0.
- Select: sel = (addr[31:8] == BASE_ADDR[31:8]). Writes act only on sel && we. Reads return data only on sel && re, otherwise 0.
- DATA write (offset 0x00):
  - Push data_write[7:0] if not full, or if full and a pop occurs in the same cycle.
  - Otherwise drop the byte and set overflow (sticky).
  - line_buf updates on every DATA write, whether or not the push succeeds: line_buf <= {line_buf[8*LINE_BYTES-9:0], byte}.
  - Exception: when lf_clear = 1 and byte == 8'h0A, line_buf <= 0 instead.
- DATA read returns 0.
- STATUS (offset 0x04, read-only; writes ignored):
  - bit0 empty, bit1 full, bit2 overflow.
  - bits[15:8] count, zero-extended.
  - All other bits 0.
- CTRL (offset 0x08):
  - bit0 tx_en, bit1 lf_clear, bit2 irq_en are read/write.
  - bit8 flush is write-only, self-clearing, and reads as 0.
  - Flush empties the FIFO, clears overflow and clears line_buf at that edge. The other CTRL bits are written in the same cycle.
- Other offsets: reads return 0, writes are ignored.
- Stream side:
  - tx_valid = tx_en && !empty; tx_data = FIFO head (0 when empty).
  - Pop occurs when tx_valid && tx_ready.
  - tx_data must not change while tx_valid && !tx_ready.
  - With tx_en = 0, the FIFO holds its contents and pushes continue.
- Latency: a byte pushed at edge N gives tx_valid = 1 from edge N onward, when the FIFO was empty and tx_en = 1. One pop per cycle gives full throughput.
- Simultaneous push and pop:
  - Count unchanged, both pointers advance.
  - When empty, only the push takes effect, because tx_valid was 0.
- Flush in the same cycle as a pop: flush wins and the FIFO ends empty.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH. full = (count == FIFO_DEPTH).
- irq = irq_en && empty. It is level-type and derived from registered state only.
- Reset mid-stream: FIFO contents are discarded immediately and tx_valid drops asynchronously.

Test Plan:
- Basic: reset, write 0x41, 0x42, 0x43 to DATA with tx_ready = 1 → tx_data 0x41, 0x42, 0x43 on consecutive cycles, tx_valid high 3 cycles, then STATUS = 0x0000_0001.
- Backpressure/overflow: tx_ready = 0, write 17 bytes 0x00..0x10 → STATUS = 0x0000_1006 (count 16, full, overflow). Raise tx_ready → 0x00..0x0F drain in order, 0x10 is lost, overflow stays 1.
- Full + simultaneous: FIFO full, tx_ready = 1 while writing 0x55 → 0x55 accepted, count stays 16, overflow stays 0.
- Line buffer: lf_clear = 1, write "HI" (0x48, 0x49) → line_buf[15:0] = 0x4849. Write 0x0A → line_buf = 0. With lf_clear = 0, 0x0A is shifted in instead.
- Control: tx_en = 0, write 2 bytes → tx_valid = 0, count = 2. Set irq_en = 1, tx_en = 1 → bytes drain and irq rises the cycle after the last pop. Write CTRL bit8 with bytes queued → STATUS = 0x1 next cycle.
- Decode/reset: write with addr = 0x0000_0100 → no effect. Assert reset_n low mid-drain → tx_valid = 0 and line_buf = 0 immediately, CTRL reads 0x1.

Source files
------------

// File: rtl/terminal_fifo.sv
// -----------------------------------------------------------------------------
// terminal_fifo
//   Memory-mapped debug terminal. CPU stores to DATA push bytes into a FIFO
//   that drains over a valid/ready byte stream. A shift buffer of the most
//   recent characters, a sticky overflow flag, STATUS/CTRL registers and a
//   level-type "FIFO drained" interrupt are provided alongside.
//
// Ports
//   clk         clock
//   reset_n     asynchronous active-low reset
//   we, re      CPU write / read strobes
//   addr        byte address; offsets 0x00 DATA, 0x04 STATUS, 0x08 CTRL
//   data_write  CPU write data
//   data_read   CPU read data (combinational, 0 unless selected and re)
//   tx_data     FIFO head byte (0 when empty)
//   tx_valid    head byte available (tx_en && !empty)
//   tx_ready    consumer accepts the head byte
//   line_buf    recent characters, newest in [7:0]
//   irq         irq_en && empty
// -----------------------------------------------------------------------------
module terminal_fifo #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 16,
   parameter int          LINE_BYTES = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    we,
   input  logic                    re,
   input  logic [31:0]             addr,
   input  logic [31:0]             data_write,
   output logic [31:0]             data_read,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic [8*LINE_BYTES-1:0] line_buf,
   output logic                    irq
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic          tx_en;
   logic          lf_clear;
   logic          irq_en;

   logic          sel;
   logic [7:0]    offset;
   logic          data_wr;
   logic          ctrl_wr;
   logic          flush;
   logic          empty;
   logic          full;
   logic          pop;
   logic          push;
   logic [7:0]    wr_byte;
   logic [7:0]    count8;
   logic [31:0]   status;
   logic [8*LINE_BYTES+7:0] line_shift;
   logic [8*LINE_BYTES-1:0] line_next;
   logic          unused_bits;

   assign sel     = (addr[31:8] == BASE_ADDR[31:8]);
   assign offset  = addr[7:0];
   assign data_wr = sel && we && (offset == 8'h00);
   assign ctrl_wr = sel && we && (offset == 8'h08);
   assign flush   = ctrl_wr && data_write[8];
   assign wr_byte = data_write[7:0];

   assign empty    = (count == '0);
   assign full     = (count == CW'(FIFO_DEPTH));
   assign tx_valid = tx_en && !empty;
   assign pop      = tx_valid && tx_ready;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign push     = data_wr && (!full || pop);

   assign tx_data = empty ? 8'h00 : mem[rd_ptr];
   assign irq     = irq_en && empty;

   // Shift the new byte in at the bottom; the oldest byte falls off the top.
   assign line_shift = {line_buf, wr_byte};
   assign line_next  = line_shift[8*LINE_BYTES-1:0];

   assign count8 = 8'(count);
   assign status = {16'h0000, count8, 5'b00000, overflow, full, empty};

   assign unused_bits = ^data_write[31:9];

   // Register read mux; unselected or non-read accesses return zero.
   always_comb begin
      data_read = 32'h0000_0000;
      if (sel && re) begin
         case (offset)
            8'h04:   data_read = status;
            8'h08:   data_read = {29'h0, irq_en, lf_clear, tx_en};
            default: data_read = 32'h0000_0000;
         endcase
      end
   end

   // FIFO storage has no reset: entries are only visible once counted in.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_byte;
      end
   end

   // Pointer, count, flag, line buffer and CTRL state. Flush overrides any
   // pop in the same cycle so the FIFO always ends empty.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         line_buf <= '0;
         tx_en    <= 1'b1;
         lf_clear <= 1'b0;
         irq_en   <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         line_buf <= '0;
         tx_en    <= data_write[0];
         lf_clear <= data_write[1];
         irq_en   <= data_write[2];
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (data_wr && !push) begin
            overflow <= 1'b1;
         end
         // The line buffer records every DATA write, dropped bytes included.
         if (data_wr) begin
            if (lf_clear && (wr_byte == 8'h0A)) begin
               line_buf <= '0;
            end else begin
               line_buf <= line_next;
            end
         end
         if (ctrl_wr) begin
            tx_en    <= data_write[0];
            lf_clear <= data_write[1];
            irq_en   <= data_write[2];
         end
      end
   end

endmodule
